// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard beside the ID stage: detects RAW/WAW hazards
// against in-flight multi-cycle results, steers PC/IF-ID/bubble controls, counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 3,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_lat_sel,
  input  logic                  branch_flush,
  input  logic                  stat_clear,
  output logic                  PC_Write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  isControl,
  output logic                  addr_ctrl,
  output logic                  hazard_stall,
  output logic [STAT_W-1:0]     stall_cycles
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [CNT_W-1:0] cnt [NREG];

  logic [CNT_W-1:0] class_lat;
  logic             rs_busy;
  logic             rt_busy;
  logic             rd_busy;
  logic             raw;
  logic             waw;
  logic             stall;
  logic             flush;
  logic             issue;
  logic             load_entry;

  always_comb begin
    class_lat = '0;
    case (id_lat_sel)
      2'd1:    class_lat = CNT_W'(LOAD_LAT);
      2'd2:    class_lat = CNT_W'(MD_LAT);
      default: class_lat = '0;
    endcase
  end

  // Register 0 is hardwired, so it never carries a pending result.
  assign rs_busy = id_uses_rs && (id_rs_addr != '0) && (cnt[id_rs_addr] != '0);
  assign rt_busy = id_uses_rt && (id_rt_addr != '0) && (cnt[id_rt_addr] != '0);
  assign rd_busy = id_reg_write && (id_rd_addr != '0) && (cnt[id_rd_addr] != '0);

  assign raw = id_valid && (rs_busy || rt_busy);
  assign waw = id_valid && rd_busy;

  // Held reset forces the idle control pattern even if branch_flush is high.
  assign flush = branch_flush && !rst;
  assign stall = (raw || waw) && !branch_flush && !rst;
  assign issue = id_valid && !stall && !branch_flush;

  assign load_entry = issue && id_reg_write && (id_rd_addr != '0) && (class_lat != '0);

  assign PC_Write     = !stall;
  assign IF_ID_write  = !stall;
  assign addr_ctrl    = !stall;
  assign isControl    = !stall && !flush;
  assign IF_ID_flush  = flush;
  assign hazard_stall = stall;

  // Older producers keep advancing every cycle; a fresh issue overrides the decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      if (load_entry) begin
        cnt[id_rd_addr] <= class_lat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stat_clear) begin
      stall_cycles <= '0;
    end else if (hazard_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: cycle-by-cycle vector table plus
// hand-written sequences for mid-countdown reset and counter saturation.
module tb_hazard_scoreboard;

  localparam logic [5:0] OUT_NORM  = 6'b110110;
  localparam logic [5:0] OUT_STALL = 6'b000001;
  localparam logic [5:0] OUT_FLUSH = 6'b111010;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic [1:0]  id_lat_sel;
  logic        branch_flush;
  logic        stat_clear;
  logic        pc_write, if_id_write, if_id_flush, is_control, addr_ctrl, hazard_stall;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_is_control, s_addr_ctrl, s_hazard_stall;
  logic [3:0]  s_stall_cycles;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_lat_sel(id_lat_sel),
    .branch_flush(branch_flush), .stat_clear(stat_clear),
    .PC_Write(pc_write), .IF_ID_write(if_id_write), .IF_ID_flush(if_id_flush),
    .isControl(is_control), .addr_ctrl(addr_ctrl), .hazard_stall(hazard_stall),
    .stall_cycles(stall_cycles)
  );

  // Narrow statistics counter so saturation is reachable in a short run.
  hazard_scoreboard #(.STAT_W(4)) u_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_lat_sel(id_lat_sel),
    .branch_flush(branch_flush), .stat_clear(stat_clear),
    .PC_Write(s_pc_write), .IF_ID_write(s_if_id_write), .IF_ID_flush(s_if_id_flush),
    .isControl(s_is_control), .addr_ctrl(s_addr_ctrl), .hazard_stall(s_hazard_stall),
    .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  lat;
    logic        br;
    logic        clr;
    logic [5:0]  e_out;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs[30];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(logic v, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                              logic [4:0] rd, logic rw, logic [1:0] lat, logic br, logic clr,
                              logic [5:0] e_out, logic [15:0] e_sc);
    vec_t t;
    t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
    t.rd = rd; t.rw = rw; t.lat = lat; t.br = br; t.clr = clr;
    t.e_out = e_out; t.e_sc = e_sc;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs_addr = t.rs; id_uses_rs = t.urs;
    id_rt_addr = t.rt; id_uses_rt = t.urt; id_rd_addr = t.rd;
    id_reg_write = t.rw; id_lat_sel = t.lat; branch_flush = t.br; stat_clear = t.clr;
  endtask

  task automatic drive_idle();
    drive(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, OUT_NORM, 16'd0));
  endtask

  task automatic drive_mul(input logic [4:0] rd);
    drive(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 2'd2, 1'b0, 1'b0, OUT_NORM, 16'd0));
  endtask

  task automatic drive_reader(input logic [4:0] rs);
    drive(mk(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, OUT_NORM, 16'd0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outs(input string name);
    logic [5:0] exp_v;
    logic [5:0] act;
    act = {pc_write, if_id_write, if_id_flush, is_control, addr_ctrl, hazard_stall};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: expected queue empty, got outs=%b", name, act);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        bad++;
        $display("FAIL %s: outs {pc,ifid_w,flush,ctrl,addr,stall} got=%b want=%b", name, act, exp_v);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp_v);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    drive_idle();

    // Cycle-by-cycle stream; e_sc is stall_cycles seen during that cycle.
    vecs[0]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, OUT_NORM, 0);   // alu r3
    vecs[1]  = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, OUT_NORM, 0);   // reads r3: forwarded
    vecs[2]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, OUT_NORM, 0);   // load r5
    vecs[3]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, OUT_STALL, 0);  // uses rt=r5
    vecs[4]  = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, OUT_NORM, 1);
    vecs[5]  = mk(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, OUT_NORM, 1);   // mul r8
    vecs[6]  = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, OUT_STALL, 1);
    vecs[7]  = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, OUT_STALL, 2);
    vecs[8]  = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, OUT_STALL, 3);
    vecs[9]  = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, OUT_STALL, 4);
    vecs[10] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, OUT_NORM, 5);
    vecs[11] = mk(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, OUT_NORM, 5);   // mul r8 again
    vecs[12] = mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, OUT_NORM, 5);   // independent
    vecs[13] = mk(1, 2, 1, 0, 0, 10, 1, 0, 0, 0, OUT_NORM, 5);  // independent
    vecs[14] = mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, OUT_STALL, 5);
    vecs[15] = mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, OUT_STALL, 6);
    vecs[16] = mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, OUT_NORM, 7);
    vecs[17] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, OUT_NORM, 7);   // load r0
    vecs[18] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, OUT_NORM, 7);   // reads r0
    vecs[19] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, OUT_NORM, 7);   // load r7
    vecs[20] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, OUT_STALL, 7);  // waw on r7
    vecs[21] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, OUT_NORM, 8);
    vecs[22] = mk(1, 0, 0, 0, 0, 12, 1, 2, 0, 0, OUT_NORM, 8);  // mul r12
    vecs[23] = mk(0, 12, 1, 0, 0, 0, 0, 0, 0, 0, OUT_NORM, 8);  // bubble, no stall
    vecs[24] = mk(1, 12, 1, 0, 0, 13, 1, 2, 0, 0, OUT_STALL, 8);
    vecs[25] = mk(1, 12, 1, 0, 0, 13, 1, 2, 1, 0, OUT_FLUSH, 9); // flush wins
    vecs[26] = mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, OUT_NORM, 9);  // r13 never booked
    vecs[27] = mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, OUT_NORM, 9);
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, OUT_NORM, 9);   // stat_clear
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OUT_NORM, 0);

    next_cycle();
    next_cycle();
    @(negedge clk);
    exp_q.push_back(OUT_NORM);
    check_outs("reset_held_outs");
    check_val("reset_held_sc", stall_cycles, 16'd0);

    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i != 0) next_cycle();
      drive(vecs[i]);
      @(negedge clk);
      exp_q.push_back(vecs[i].e_out);
      check_outs($sformatf("vec%0d_outs", i));
      check_val($sformatf("vec%0d_sc", i), stall_cycles, vecs[i].e_sc);
    end

    // Reset in the middle of a mul/div countdown.
    next_cycle();
    drive_mul(5'd20);
    @(negedge clk);
    exp_q.push_back(OUT_NORM);
    check_outs("mid_rst_mul_issue");
    next_cycle();
    drive_reader(5'd20);
    @(negedge clk);
    exp_q.push_back(OUT_STALL);
    check_outs("mid_rst_pre_stall");
    #1;
    rst = 1'b1;
    branch_flush = 1'b1;
    #1;
    exp_q.push_back(OUT_NORM);
    check_outs("mid_rst_async_outs");
    check_val("mid_rst_sc", stall_cycles, 16'd0);
    check_val("mid_rst_small_sc", {12'd0, s_stall_cycles}, 16'd0);
    next_cycle();
    rst = 1'b0;
    branch_flush = 1'b0;
    @(negedge clk);
    exp_q.push_back(OUT_NORM);
    check_outs("post_rst_reader_r20");

    // Saturation: 5 rounds x 4 stalls = 20 stall cycles; 4-bit counter holds at 15.
    for (int r = 0; r < 5; r++) begin
      next_cycle();
      drive_mul(5'd21);
      for (int c = 0; c < 5; c++) begin
        next_cycle();
        drive_reader(5'd21);
        @(negedge clk);
        exp_q.push_back((c < 4) ? OUT_STALL : OUT_NORM);
        check_outs($sformatf("sat_r%0d_c%0d", r, c));
      end
    end
    check_val("sat_main_sc", stall_cycles, 16'd20);
    check_val("sat_small_sc", {12'd0, s_stall_cycles}, 16'd15);

    next_cycle();
    drive_idle();
    stat_clear = 1'b1;
    next_cycle();
    stat_clear = 1'b0;
    @(negedge clk);
    check_val("clear_main_sc", stall_cycles, 16'd0);
    check_val("clear_small_sc", {12'd0, s_stall_cycles}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
